// File: rtl/debounce_pkg.sv
// ---------------------------------------------------------------------------
// debounce_pkg
//   Shared types and default constants for the pushbutton debouncer.
//   db_state_t       : debounce FSM state encoding
//   DB_SYNC_STAGES   : default synchroniser depth
//   DB_STABLE_CYCLES : default number of steady samples before the level flips
// ---------------------------------------------------------------------------
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } db_state_t;

    localparam int DB_SYNC_STAGES   = 2;
    localparam int DB_STABLE_CYCLES = 4;

endpackage : debounce_pkg

// File: rtl/btn_debounce_pulse_sync_chain.sv
// ---------------------------------------------------------------------------
// sync_chain
//   Multi-flop synchroniser for a single asynchronous bit. Every flop is
//   cleared by the asynchronous active-low reset.
//   Ports:
//     clk     : sampling clock
//     reset_n : asynchronous active-low reset
//     d       : asynchronous input
//     q       : synchronised output (last flop of the chain)
// ---------------------------------------------------------------------------
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule : sync_chain

// File: rtl/btn_debounce_pulse.sv
// ---------------------------------------------------------------------------
// btn_debounce_pulse
//   Synchronises a raw button input, rejects contact bounce and drives a
//   clean registered level plus one-cycle edge pulses.
//
//   Optional feature macro: DEBOUNCE_FALL_PULSE_EN
//     defined     -> btn_fall port exists and pulses on the debounced 1->0
//     not defined -> btn_fall absent; the falling exit only clears btn_level
//
//   Ports:
//     clk       : system clock, all state updates on posedge
//     reset_n   : asynchronous active-low reset
//     btn_in    : raw asynchronous button input (may bounce)
//     btn_level : debounced level, registered
//     btn_rise  : one-cycle pulse on the debounced 0->1, registered
//     btn_fall  : one-cycle pulse on the debounced 1->0, registered
//                 (only with DEBOUNCE_FALL_PULSE_EN)
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   IDLE_LOW  | level is 0, input agrees
//   WAIT_HIGH | level is 0, counting consecutive high samples
//   IDLE_HIGH | level is 1, input agrees
//   WAIT_LOW  | level is 1, counting consecutive low samples
// ---------------------------------------------------------------------------
module btn_debounce_pulse
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = DB_SYNC_STAGES,
    parameter int STABLE_CYCLES = DB_STABLE_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_in,
    output logic btn_level,
`ifdef DEBOUNCE_FALL_PULSE_EN
    output logic btn_fall,
`endif
    output logic btn_rise
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    // Entering WAIT_* already accounts for the first steady sample, so the
    // level flips when the count reaches STABLE_CYCLES-1 with one more sample.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("btn_debounce_pulse: SYNC_STAGES must be >= 2");
    end
    if (STABLE_CYCLES < 2) begin : g_bad_stable
        $error("btn_debounce_pulse: STABLE_CYCLES must be >= 2");
    end

    logic             sync_out;
    db_state_t        state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             level_next;
    logic             rise_next;
`ifdef DEBOUNCE_FALL_PULSE_EN
    logic             fall_next;
`endif

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (btn_in),
        .q       (sync_out)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE_LOW;
            cnt       <= '0;
            btn_level <= 1'b0;
            btn_rise  <= 1'b0;
`ifdef DEBOUNCE_FALL_PULSE_EN
            btn_fall  <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            btn_level <= level_next;
            btn_rise  <= rise_next;
`ifdef DEBOUNCE_FALL_PULSE_EN
            btn_fall  <= fall_next;
`endif
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        level_next = btn_level;
        rise_next  = 1'b0;
`ifdef DEBOUNCE_FALL_PULSE_EN
        fall_next  = 1'b0;
`endif
        case (state)
            IDLE_LOW: begin
                if (sync_out) begin
                    state_next = WAIT_HIGH;
                    cnt_next   = CNT_ONE;
                end else begin
                    cnt_next   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!sync_out) begin
                    state_next = IDLE_LOW;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE_HIGH;
                    cnt_next   = '0;
                    level_next = 1'b1;
                    rise_next  = 1'b1;
                end else begin
                    cnt_next   = cnt + CNT_ONE;
                end
            end
            IDLE_HIGH: begin
                if (!sync_out) begin
                    state_next = WAIT_LOW;
                    cnt_next   = CNT_ONE;
                end else begin
                    cnt_next   = '0;
                end
            end
            WAIT_LOW: begin
                if (sync_out) begin
                    state_next = IDLE_HIGH;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE_LOW;
                    cnt_next   = '0;
                    level_next = 1'b0;
`ifdef DEBOUNCE_FALL_PULSE_EN
                    fall_next  = 1'b1;
`endif
                end else begin
                    cnt_next   = cnt + CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE_LOW;
                cnt_next   = '0;
                level_next = 1'b0;
            end
        endcase
    end

endmodule : btn_debounce_pulse

// File: tb/tb_btn_debounce_pulse.sv
// ---------------------------------------------------------------------------
// tb_btn_debounce_pulse
//   Self-checking bench: a behavioural run-length model predicts the outputs
//   of the default-parameter instance each cycle and queues them; the queue
//   is popped and compared after every posedge. A second instance with
//   SYNC_STAGES=3, STABLE_CYCLES=8 is checked for its 11-edge latency.
// ---------------------------------------------------------------------------
module tb_btn_debounce_pulse;

    localparam int S_A = 2;
    localparam int N_A = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic btn_in = 1'b0;
    logic btn_b = 1'b0;
    logic level_a, rise_a, level_b, rise_b;
`ifdef DEBOUNCE_FALL_PULSE_EN
    logic fall_a, fall_b;
`endif

    always #5 clk = ~clk;

    btn_debounce_pulse dut_a (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn_in    (btn_in),
        .btn_level (level_a),
`ifdef DEBOUNCE_FALL_PULSE_EN
        .btn_fall  (fall_a),
`endif
        .btn_rise  (rise_a)
    );

    btn_debounce_pulse #(
        .SYNC_STAGES   (3),
        .STABLE_CYCLES (8)
    ) dut_b (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn_in    (btn_b),
        .btn_level (level_b),
`ifdef DEBOUNCE_FALL_PULSE_EN
        .btn_fall  (fall_b),
`endif
        .btn_rise  (rise_b)
    );

    int n_checks = 0;
    int n_errors = 0;
    int rise_cnt = 0;
    int fall_cnt = 0;

    // model state: synchroniser history, level, length of disagreeing run
    logic [S_A-1:0] m_sync = '0;
    logic           m_level = 1'b0;
    int             m_run = 0;
    logic [2:0]     exp_q[$];   // {level, rise, fall}

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sync  = '0;
        m_level = 1'b0;
        m_run   = 0;
        exp_q.delete();
    endtask

    // Predict the outputs after the coming posedge given input b.
    task automatic model_push(input logic b);
        logic s, r, f;
        s = m_sync[S_A-1];
        m_sync = {m_sync[S_A-2:0], b};
        r = 1'b0;
        f = 1'b0;
        if (s != m_level) begin
            m_run++;
            if (m_run == N_A) begin
                m_level = s;
                r = s;
                f = ~s;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        exp_q.push_back({m_level, r, f});
    endtask

    // Drive one cycle of input, then compare the scoreboard entry #1 after the edge.
    task automatic tick(input logic b);
        logic [2:0] e;
        btn_in = b;
        model_push(b);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("sb_level", {31'd0, level_a}, {31'd0, e[2]});
            check("sb_rise",  {31'd0, rise_a},  {31'd0, e[1]});
`ifdef DEBOUNCE_FALL_PULSE_EN
            check("sb_fall",  {31'd0, fall_a},  {31'd0, e[0]});
            if (fall_a) fall_cnt++;
`endif
        end
        if (rise_a) rise_cnt++;
    endtask

    // Assert reset between edges, check outputs clear immediately, release between edges.
    task automatic apply_reset(input logic b, input string tag);
        #2;
        reset_n = 1'b0;
        btn_in  = b;
        #1;
        check({tag, "_lvl_a"},  {31'd0, level_a}, 32'd0);
        check({tag, "_rise_a"}, {31'd0, rise_a},  32'd0);
        check({tag, "_lvl_b"},  {31'd0, level_b}, 32'd0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #3;
        reset_n = 1'b1;
    endtask

    int first;

    initial begin
        // 1: reset with input high, then held high
        apply_reset(1'b1, "t1_rst");
        rise_cnt = 0;
        for (int i = 1; i <= 9; i++) begin
            tick(1'b1);
            if (i == 5) check("t1_lvl_at5", {31'd0, level_a}, 32'd0);
            if (i == 6) check("t1_lvl_at6", {31'd0, level_a}, 32'd1);
            if (i == 6) check("t1_rise_at6", {31'd0, rise_a}, 32'd1);
            if (i == 7) check("t1_rise_at7", {31'd0, rise_a}, 32'd0);
        end
        check("t1_rise_cnt", rise_cnt, 32'd1);

        // 4: from level 1, held low
        rise_cnt = 0;
        fall_cnt = 0;
        first = 0;
        for (int i = 1; i <= 9; i++) begin
            tick(1'b0);
            if (first == 0 && level_a == 1'b0) first = i;
        end
        check("t4_fall_latency", first, 32'd6);
        check("t4_rise_cnt", rise_cnt, 32'd0);
`ifdef DEBOUNCE_FALL_PULSE_EN
        check("t4_fall_cnt", fall_cnt, 32'd1);
`endif

        // 2: short high glitch rejected
        rise_cnt = 0;
        for (int i = 0; i < 3; i++) tick(1'b1);
        for (int i = 0; i < 8; i++) tick(1'b0);
        check("t2_level", {31'd0, level_a}, 32'd0);
        check("t2_rise_cnt", rise_cnt, 32'd0);

        // 3: toggling for 10 cycles, then held high
        rise_cnt = 0;
        for (int i = 0; i < 10; i++) tick((i % 2) == 0 ? 1'b1 : 1'b0);
        check("t3_lvl_toggle", {31'd0, level_a}, 32'd0);
        first = 0;
        for (int i = 1; i <= 9; i++) begin
            tick(1'b1);
            if (first == 0 && level_a == 1'b1) first = i;
        end
        check("t3_latency", first, 32'd6);
        check("t3_rise_cnt", rise_cnt, 32'd1);

        // random bouncing against the model
        for (int i = 0; i < 200; i++) tick(1'(($urandom_range(0, 9) < 3) ? ~m_sync[0] : m_sync[0]));

        // 5: reset in WAIT_HIGH with cnt=2, then held high
        apply_reset(1'b0, "t5_pre");
        for (int i = 0; i < 4; i++) tick(1'b1);
        apply_reset(1'b1, "t5_wait");
        rise_cnt = 0;
        first = 0;
        for (int i = 1; i <= 8; i++) begin
            tick(1'b1);
            if (first == 0 && level_a == 1'b1) first = i;
        end
        check("t5_latency", first, 32'd6);
        check("t5_rise_cnt", rise_cnt, 32'd1);

        // reset while level is high must drop the level before the next edge
        apply_reset(1'b1, "t5_high");

        // 6: SYNC_STAGES=3, STABLE_CYCLES=8 clean step
        btn_b = 1'b1;
        for (int i = 1; i <= 13; i++) begin
            tick(1'b0);
            if (i == 10) check("t6_lvl_at10", {31'd0, level_b}, 32'd0);
            if (i == 11) check("t6_lvl_at11", {31'd0, level_b}, 32'd1);
            if (i == 11) check("t6_rise_at11", {31'd0, rise_b}, 32'd1);
            if (i == 12) check("t6_rise_at12", {31'd0, rise_b}, 32'd0);
        end

        check("sb_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule : tb_btn_debounce_pulse
